tcp_listen_port_manager: RTL and testbench

Opens a configurable set of consecutive TCP listen ports on the TOE at start-up and replaces the fixed single-port, fire-and-forget opener in the loopback top. It issues one listen request per port with a full AXI-Stream handshake and checks the listen status returned for each request. A failed or timed-out port is retried after a programmable interval, up to a retry limit. Per-port open/fail state is exported to the user kernel and to debug.

---
 rtl/tcp_listen_pkg.sv | 16 +
 rtl/tcp_interval_timer.sv | 29 ++
 rtl/tcp_listen_port_manager.sv | 179 +++++++++++++++++
 tb/tb_tcp_listen_port_manager.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_listen_pkg.sv
// Shared types and constants for the TCP listen-port manager.
package tcp_listen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_STS,
    ST_NEXT,
    ST_DONE
  } listen_state_t;

  localparam int          LISTEN_STS_OK_BIT   = 0;
  localparam logic [15:0] DEFAULT_LISTEN_PORT = 16'h0B48;

endpackage

// File: rtl/tcp_interval_timer.sv
// Loadable down-counter with a zero flag; shared by the retry interval and
// the status timeout of the listen-port manager.
module tcp_interval_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tcp_listen_port_manager.sv
// Opens NUM_PORTS consecutive TOE listen ports with retries and reports
// per-port open/failed state. Optional status timeout: LISTEN_STATUS_TIMEOUT_EN.
module tcp_listen_port_manager
  import tcp_listen_pkg::*;
#(
  parameter int          NUM_PORTS      = 4,
  parameter logic [15:0] BASE_PORT      = DEFAULT_LISTEN_PORT,
  parameter int          RETRY_CYCLES   = 32768,
  parameter int          MAX_RETRIES    = 8,
  parameter int          STATUS_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 m_axis_listen_port_TVALID,
  input  logic                 m_axis_listen_port_TREADY,
  output logic [15:0]          m_axis_listen_port_TDATA,
  input  logic                 s_axis_listen_port_status_TVALID,
  output logic                 s_axis_listen_port_status_TREADY,
  input  logic [7:0]           s_axis_listen_port_status_TDATA,
  output logic [NUM_PORTS-1:0] port_open,
  output logic [NUM_PORTS-1:0] port_failed,
  output logic                 done
);

  localparam int IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int ATT_W   = $clog2(MAX_RETRIES + 1);
  localparam int TMR_MAX = (RETRY_CYCLES > STATUS_TIMEOUT) ? RETRY_CYCLES : STATUS_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PORTS - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT  = ATT_W'(MAX_RETRIES);
  localparam logic [TMR_W-1:0] RETRY_LOAD = TMR_W'(RETRY_CYCLES);
`ifdef LISTEN_STATUS_TIMEOUT_EN
  localparam logic [TMR_W-1:0] STS_LOAD   = TMR_W'(STATUS_TIMEOUT);
`endif

  listen_state_t        state, state_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [ATT_W-1:0]     attempts, attempts_nx;
  logic                 tvalid_nx;
  logic [15:0]          tdata_nx;
  logic [NUM_PORTS-1:0] open_nx, failed_nx, port_bit;
  logic                 done_nx;
  logic                 timer_load, timer_dec, timer_zero;
  logic [TMR_W-1:0]     timer_value;
  logic                 sts_ok, sts_fail;
  logic                 unused_sts;

  assign s_axis_listen_port_status_TREADY = 1'b1;
  assign sts_ok     = s_axis_listen_port_status_TDATA[LISTEN_STS_OK_BIT];
  assign unused_sts = ^s_axis_listen_port_status_TDATA;
  assign port_bit   = NUM_PORTS'(1) << idx;

  tcp_interval_timer #(.WIDTH(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= ST_IDLE;
      idx                       <= '0;
      attempts                  <= '0;
      m_axis_listen_port_TVALID <= 1'b0;
      m_axis_listen_port_TDATA  <= '0;
      port_open                 <= '0;
      port_failed               <= '0;
      done                      <= 1'b0;
    end else begin
      state                     <= state_nx;
      idx                       <= idx_nx;
      attempts                  <= attempts_nx;
      m_axis_listen_port_TVALID <= tvalid_nx;
      m_axis_listen_port_TDATA  <= tdata_nx;
      port_open                 <= open_nx;
      port_failed               <= failed_nx;
      done                      <= done_nx;
    end
  end

  // TVALID/TDATA are computed on the transition into REQ so they leave the
  // block straight from flops and stay frozen until the handshake.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    attempts_nx = attempts;
    tvalid_nx   = m_axis_listen_port_TVALID;
    tdata_nx    = m_axis_listen_port_TDATA;
    open_nx     = port_open;
    failed_nx   = port_failed;
    done_nx     = done;
    timer_load  = 1'b0;
    timer_value = RETRY_LOAD;
    timer_dec   = 1'b0;
    sts_fail    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          timer_load  = 1'b1;
          idx_nx      = '0;
          attempts_nx = '0;
          state_nx    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          tvalid_nx = 1'b1;
          tdata_nx  = BASE_PORT + 16'(idx);
          state_nx  = ST_REQ;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_REQ: begin
        if (m_axis_listen_port_TREADY) begin
          tvalid_nx   = 1'b0;
          attempts_nx = attempts + 1'b1;
          state_nx    = ST_STS;
`ifdef LISTEN_STATUS_TIMEOUT_EN
          timer_load  = 1'b1;
          timer_value = STS_LOAD;
`endif
        end
      end
      ST_STS: begin
        // A status beat outranks a timeout expiring in the same cycle.
        if (s_axis_listen_port_status_TVALID) begin
          if (sts_ok) begin
            open_nx  = port_open | port_bit;
            state_nx = ST_NEXT;
          end else begin
            sts_fail = 1'b1;
          end
        end
`ifdef LISTEN_STATUS_TIMEOUT_EN
        else if (timer_zero) begin
          sts_fail = 1'b1;
        end else begin
          timer_dec = 1'b1;
        end
`endif
        if (sts_fail) begin
          if (attempts < ATT_LIMIT) begin
            timer_load = 1'b1;
            state_nx   = ST_WAIT;
          end else begin
            failed_nx = port_failed | port_bit;
            state_nx  = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        attempts_nx = '0;
        if (idx == LAST_IDX) begin
          done_nx  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          idx_nx    = idx + 1'b1;
          tvalid_nx = 1'b1;
          tdata_nx  = BASE_PORT + 16'(idx + 1'b1);
          state_nx  = ST_REQ;
        end
      end
      ST_DONE: begin
        state_nx = ST_DONE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tcp_listen_port_manager.sv
// Self-checking bench for tcp_listen_port_manager: table scenarios, directed
// corner cases and randomized TOE behaviour against a per-port outcome model.
module tb_tcp_listen_port_manager;

  localparam int          NP   = 4;
  localparam logic [15:0] BASE = 16'h0B48;
  localparam int          RC   = 16;
  localparam int          MR   = 3;
  localparam int          STO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          req_valid;
  logic          req_ready = 1'b1;
  logic [15:0]   req_data;
  logic          sts_valid = 1'b0;
  logic          sts_ready;
  logic [7:0]    sts_data = 8'h00;
  logic [NP-1:0] port_open, port_failed;
  logic          done;

  always #5 clk = ~clk;

  tcp_listen_port_manager #(
    .NUM_PORTS      (NP),
    .BASE_PORT      (BASE),
    .RETRY_CYCLES   (RC),
    .MAX_RETRIES    (MR),
    .STATUS_TIMEOUT (STO)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .enable                           (enable),
    .m_axis_listen_port_TVALID        (req_valid),
    .m_axis_listen_port_TREADY        (req_ready),
    .m_axis_listen_port_TDATA         (req_data),
    .s_axis_listen_port_status_TVALID (sts_valid),
    .s_axis_listen_port_status_TREADY (sts_ready),
    .s_axis_listen_port_status_TDATA  (sts_data),
    .port_open                        (port_open),
    .port_failed                      (port_failed),
    .done                             (done)
  );

  // nfail[p]: how many leading attempts on port p get a failing status.
  typedef struct packed {
    logic [NP-1:0][1:0] nfail;
    logic               stall;
    logic [NP-1:0]      exp_open;
    logic [NP-1:0]      exp_failed;
    logic [7:0]         exp_nreq;
  } vec_t;

  vec_t vecs[6];

  int          n_vec = 0;
  int          n_err = 0;
  int          ncount = 0;
  logic        rst_next = 1'b1;
  logic        en_next = 1'b0;
  int          nfail[NP];
  int          att[NP];
  logic [15:0] got_reqs[$];
  logic [15:0] exp_reqs[$];
  logic [NP-1:0] model_open, model_failed;
  int          stall_left = 0;
  bit          prev_stalled = 0;
  logic [15:0] prev_tdata = 16'h0;
  bit          pend = 0, pend_ok = 0, pend_final = 0, pend_silent = 0;
  int          pend_port = 0, pend_delay = 0;
  int          force_delay = -1;
  bit          silent_next = 0;
  int          mute_port = -1;
  int          exp_kind = 0, exp_neg = 0;
  bit          bit_chk = 0, bit_open = 0, bit_failed = 0;
  int          bit_neg = 0, bit_port = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A status decision reaches the DUT on the posedge after this negedge.
  task automatic beatEvent();
    bit_chk    = 1;
    bit_neg    = ncount + 1;
    bit_port   = pend_port;
    bit_open   = pend_ok;
    bit_failed = pend_final && !pend_ok;
    if (!pend_final) begin
      exp_kind = 1;
      exp_neg  = ncount + RC + 2;
    end else if (pend_port != NP - 1) begin
      exp_kind = 1;
      exp_neg  = ncount + 2;
    end else begin
      exp_kind = 2;
      exp_neg  = ncount + 2;
    end
  endtask

  // One clock: check timing expectations, then drive TOE-side inputs for the next posedge.
  task automatic tick();
    logic s;
    int   p;
    @(negedge clk);
    ncount++;
    rst    = rst_next;
    enable = en_next;
    if (exp_kind != 0) begin
      s = (exp_kind == 1) ? req_valid : done;
      if (ncount == exp_neg - 1) begin
        if (exp_kind == 1) checkOutput("tvalid_early", {31'd0, s}, 32'd0);
        else               checkOutput("done_early", {31'd0, s}, 32'd0);
      end else if (ncount == exp_neg) begin
        if (exp_kind == 1) checkOutput("tvalid_rise", {31'd0, s}, 32'd1);
        else               checkOutput("done_rise", {31'd0, s}, 32'd1);
        exp_kind = 0;
      end
    end
    if (bit_chk && ncount == bit_neg) begin
      checkOutput("port_open_bit", {31'd0, port_open[bit_port]}, {31'd0, bit_open});
      checkOutput("port_failed_bit", {31'd0, port_failed[bit_port]}, {31'd0, bit_failed});
      bit_chk = 0;
    end
    if (prev_stalled) begin
      checkOutput("hold_tvalid", {31'd0, req_valid}, 32'd1);
      checkOutput("hold_tdata", {16'd0, req_data}, {16'd0, prev_tdata});
    end
    if (rst) begin
      req_ready    = 1'b1;
      sts_valid    = 1'b0;
      prev_stalled = 0;
      pend         = 0;
      exp_kind     = 0;
      bit_chk      = 0;
      return;
    end
    if (stall_left > 0 && req_valid) begin
      req_ready = 1'b0;
      stall_left--;
    end else begin
      req_ready = ($urandom_range(0, 3) != 0);
    end
    prev_stalled = req_valid && !req_ready;
    prev_tdata   = req_data;
    sts_valid    = 1'b0;
    sts_data     = 8'($urandom_range(0, 255));
    if (req_valid && req_ready) begin
      got_reqs.push_back(req_data);
      p = int'(req_data - BASE);
      if (p >= 0 && p < NP && p != mute_port) begin
        pend_ok    = (att[p] >= nfail[p]);
        att[p]++;
        pend_final = pend_ok || (att[p] >= MR);
        pend_port  = p;
        pend       = 1;
        pend_delay = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
        force_delay = -1;
        pend_silent = silent_next;
        silent_next = 0;
      end
    end else if (pend) begin
      if (pend_delay == 0) begin
        if (!pend_silent) begin
          sts_valid = 1'b1;
          sts_data  = {sts_data[7:1], pend_ok};
        end
        beatEvent();
        pend = 0;
      end else begin
        pend_delay--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      sts_valid   = 1'b1;
      sts_data[0] = 1'b1;
    end
  endtask

  // Spec-level outcome: port p is tried min(nfail+1, MR) times, open iff nfail < MR.
  task automatic modelRun();
    int n;
    exp_reqs.delete();
    for (int p = 0; p < NP; p++) begin
      n = (nfail[p] < MR) ? nfail[p] + 1 : MR;
      for (int k = 0; k < n; k++) exp_reqs.push_back(BASE + 16'(p));
      model_open[p]   = (nfail[p] < MR);
      model_failed[p] = !(nfail[p] < MR);
    end
  endtask

  task automatic startRun(input bit with_reset);
    for (int p = 0; p < NP; p++) att[p] = 0;
    got_reqs.delete();
    pend = 0; exp_kind = 0; bit_chk = 0; prev_stalled = 0;
    if (with_reset) begin
      rst_next = 1'b1; en_next = 1'b0;
      tick(); tick();
    end
    rst_next = 1'b0; en_next = 1'b1;
    tick();
    exp_kind = 1;
    exp_neg  = ncount + RC + 2;
  endtask

  task automatic runToDone();
    tick(); tick(); tick();
    en_next = logic'($urandom_range(0, 1));
    for (int i = 0; i < 4000 && !done; i++) tick();
    checkOutput("done", {31'd0, done}, 32'd1);
    tick(); tick();
  endtask

  task automatic checkSequence();
    modelRun();
    checkOutput("req_count", got_reqs.size(), exp_reqs.size());
    for (int i = 0; i < got_reqs.size() && i < exp_reqs.size(); i++)
      checkOutput("req_port", {16'd0, got_reqs[i]}, {16'd0, exp_reqs[i]});
    checkOutput("sts_tready", {31'd0, sts_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int p = 0; p < NP; p++) nfail[p] = int'(v.nfail[p]);
    stall_left = v.stall ? 5 : 0;
    startRun(1'b1);
    runToDone();
  endtask

  initial begin
    logic [NP-1:0] open_before;
    vecs[0] = '{nfail:{2'd0,2'd0,2'd0,2'd0}, stall:1'b0, exp_open:4'hF, exp_failed:4'h0, exp_nreq:8'd4};
    vecs[1] = '{nfail:{2'd0,2'd0,2'd0,2'd0}, stall:1'b1, exp_open:4'hF, exp_failed:4'h0, exp_nreq:8'd4};
    vecs[2] = '{nfail:{2'd0,2'd0,2'd2,2'd0}, stall:1'b0, exp_open:4'hF, exp_failed:4'h0, exp_nreq:8'd6};
    vecs[3] = '{nfail:{2'd0,2'd3,2'd0,2'd0}, stall:1'b0, exp_open:4'b1011, exp_failed:4'b0100, exp_nreq:8'd6};
    vecs[4] = '{nfail:{2'd3,2'd3,2'd3,2'd3}, stall:1'b1, exp_open:4'h0, exp_failed:4'hF, exp_nreq:8'd12};
    vecs[5] = '{nfail:{2'd3,2'd2,2'd0,2'd1}, stall:1'b0, exp_open:4'b0111, exp_failed:4'b1000, exp_nreq:8'd9};

    tick(); tick();
    checkOutput("rst_tvalid", {31'd0, req_valid}, 32'd0);
    checkOutput("rst_tdata", {16'd0, req_data}, 32'd0);
    checkOutput("rst_open", {28'd0, port_open}, 32'd0);
    checkOutput("rst_failed", {28'd0, port_failed}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_sts_tready", {31'd0, sts_ready}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v]);
      checkOutput("vec_open", {28'd0, port_open}, {28'd0, vecs[v].exp_open});
      checkOutput("vec_failed", {28'd0, port_failed}, {28'd0, vecs[v].exp_failed});
      checkOutput("vec_nreq", got_reqs.size(), {24'd0, vecs[v].exp_nreq});
      checkSequence();
    end

    // Reset while waiting in STS for port 2, then restart from port 0.
    for (int p = 0; p < NP; p++) nfail[p] = 0;
    stall_left = 0;
    mute_port  = 2;
    startRun(1'b1);
    for (int i = 0; i < 2000 && got_reqs.size() < 3; i++) tick();
    checkOutput("reached_port2", got_reqs.size(), 32'd3);
    rst_next = 1'b1;
    tick();
    open_before = port_open;
    tick();
    checkOutput("pre_rst_open", {28'd0, open_before}, 32'h3);
    checkOutput("midrst_tvalid", {31'd0, req_valid}, 32'd0);
    checkOutput("midrst_tdata", {16'd0, req_data}, 32'd0);
    checkOutput("midrst_open", {28'd0, port_open}, 32'd0);
    checkOutput("midrst_failed", {28'd0, port_failed}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    mute_port = -1;
    startRun(1'b0);
    runToDone();
    checkOutput("restart_open", {28'd0, port_open}, 32'hF);
    checkSequence();

    // Status beat on the last cycle a timeout build would wait.
    startRun(1'b1);
    force_delay = STO;
    runToDone();
    checkOutput("late_beat_open", {28'd0, port_open}, 32'hF);
    checkSequence();

`ifdef LISTEN_STATUS_TIMEOUT_EN
    // No status at all for port 0's first request: timeout acts as a failure.
    nfail[0] = 1;
    startRun(1'b1);
    silent_next = 1;
    runToDone();
    checkOutput("timeout_open", {28'd0, port_open}, 32'hF);
    checkSequence();
    nfail[0] = 0;
`endif

    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NP; p++) nfail[p] = $urandom_range(0, MR);
      stall_left = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : 0;
      startRun(1'b1);
      runToDone();
      modelRun();
      checkOutput("rand_open", {28'd0, port_open}, {28'd0, model_open});
      checkOutput("rand_failed", {28'd0, port_failed}, {28'd0, model_failed});
      checkSequence();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
